alu_muldiv_unit: RTL and testbench

// Multi-cycle RV32M multiply/divide unit beside the single-cycle ALU in the EX stage; parametrised in datapath width.

---
 rtl/alu_muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring divider
// sharing one 2*WIDTH working register, with a start/busy/done handshake.
module alu_muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       ALUOp,
   input  logic [6:0]       Funct7,
   input  logic [2:0]       Funct3,
   input  logic             start,
   input  logic             kill,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             md_sel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [2:0]           op_q, op_d;
   logic                 sign_a_q, sign_a_d;
   logic                 sign_b_q, sign_b_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [WIDTH-1:0]     result_q, result_d;

   logic                 is_div, signed_a, signed_b, a_neg, b_neg, div_zero, div_ovf;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0]   mul_next, div_next, step_next, p_fix;
   logic [WIDTH-1:0]     q_fix, r_fix, final_res;

   assign md_sel = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
   assign busy   = (state_q != StIdle);
   assign done   = (state_q == StDone) && !kill;
   assign result = result_q;

   // Operand decode at accept time
   always_comb begin
      is_div   = Funct3[2];
      signed_a = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) ||
                 (Funct3 == 3'b110);
      signed_b = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
      a_neg    = signed_a && operand_a[WIDTH-1];
      b_neg    = signed_b && operand_b[WIDTH-1];
      a_mag    = a_neg ? ({WIDTH{1'b0}} - operand_a) : operand_a;
      b_mag    = b_neg ? ({WIDTH{1'b0}} - operand_b) : operand_b;
      div_zero = is_div && (operand_b == {WIDTH{1'b0}});
      div_ovf  = is_div && !Funct3[0] && (operand_a == MinVal) && (operand_b == {WIDTH{1'b1}});
   end

   // One iteration: upper half is accumulator/remainder, lower half multiplier/quotient
   always_comb begin
      mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
      mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
      div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      step_next = op_q[2] ? div_next : mul_next;
      p_fix     = (sign_a_q ^ sign_b_q) ? ({(2*WIDTH){1'b0}} - step_next) : step_next;
      q_fix     = (sign_a_q ^ sign_b_q) ? ({WIDTH{1'b0}} - step_next[WIDTH-1:0])
                                        : step_next[WIDTH-1:0];
      r_fix     = sign_a_q ? ({WIDTH{1'b0}} - step_next[2*WIDTH-1:WIDTH])
                           : step_next[2*WIDTH-1:WIDTH];
      case (op_q)
         3'b000:         final_res = p_fix[WIDTH-1:0];
         3'b100, 3'b101: final_res = q_fix;
         3'b110, 3'b111: final_res = r_fix;
         default:        final_res = p_fix[2*WIDTH-1:WIDTH];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      opb_d    = opb_q;
      prod_d   = prod_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (start && md_sel && !kill) begin
               op_d     = Funct3;
               sign_a_d = a_neg;
               sign_b_d = b_neg;
               opb_d    = is_div ? b_mag : a_mag;
               prod_d   = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
               cnt_d    = CntW'(WIDTH);
               if (div_zero) begin
                  result_d = Funct3[1] ? operand_a : {WIDTH{1'b1}};
                  state_d  = StDone;
               end else if (div_ovf) begin
                  result_d = Funct3[1] ? {WIDTH{1'b0}} : MinVal;
                  state_d  = StDone;
               end else begin
                  state_d  = StRun;
               end
            end
         end
         StRun: begin
            if (kill) begin
               state_d = StIdle;
            end else begin
               prod_d = step_next;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) begin
                  result_d = final_res;
                  state_d  = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         op_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         opb_q    <= '0;
         prod_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         opb_q    <= opb_d;
         prod_q   <= prod_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: arithmetic results, latency, special cases, kill and reset.
module tb_alu_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic [1:0]  ALUOp;
   logic [6:0]  Funct7;
   logic [2:0]  Funct3;
   logic        start;
   logic        kill;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        md_sel;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;
   int lat;

   alu_muldiv_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ALUOp     (ALUOp),
      .Funct7    (Funct7),
      .Funct3    (Funct3),
      .start     (start),
      .kill      (kill),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .md_sel    (md_sel),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a request in the current cycle; returns #1 after accept edge T (cycle T+1)
   task automatic do_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      ALUOp     = 2'b10;
      Funct7    = 7'b0000001;
      Funct3    = f3;
      operand_a = a;
      operand_b = b;
      start     = 1'b1;
      step();
      start     = 1'b0;
      Funct3    = 3'b011;
      operand_a = 32'hA5A5_5A5A;
      operand_b = 32'h1234_5678;
   endtask

   // Latency counted so that done in cycle T+n gives n
   task automatic wait_done(output int n);
      n = 1;
      while (!done && n < 100) begin
         step();
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      do_start(f3, a, b);
      wait_done(lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_res"}, result, exp);
      step();
      check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; ALUOp = 2'b00; Funct7 = 7'd0; Funct3 = 3'd0;
      start = 1'b0; kill = 1'b0; operand_a = '0; operand_b = '0;
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      rst_n = 1'b1;
      step();

      // 1. MUL with busy profile
      ALUOp = 2'b10; Funct7 = 7'b0000001; #1;
      check("md_sel_on", {31'd0, md_sel}, 32'd1);
      check("accept_cycle_busy", {31'd0, busy}, 32'd0);
      do_start(3'b000, 32'd7, 32'hFFFF_FFFD);
      check("mul_busy_t1", {31'd0, busy}, 32'd1);
      check("mul_done_t1", {31'd0, done}, 32'd0);
      wait_done(lat);
      check("mul_lat", 32'(lat), 32'd33);
      check("mul_res", result, 32'hFFFF_FFEB);
      check("mul_busy_t33", {31'd0, busy}, 32'd1);
      step();
      check("mul_busy_t34", {31'd0, busy}, 32'd0);
      check("mul_done_t34", {31'd0, done}, 32'd0);

      // 2. High-half multiplies
      run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);

      // 3. Divides
      run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
      run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);

      // 4. Special cases finish one cycle after accept
      run_op("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("remu_z", 3'b111, 32'd5, 32'd0, 32'd5, 1);
      run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

      // 5. kill mid-divide; stray start in RUN ignored
      do_start(3'b100, 32'd1000, 32'd10);
      repeat (4) step();
      ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      kill = 1'b1; #1;
      check("kill_t10_busy", {31'd0, busy}, 32'd1);
      check("kill_t10_done", {31'd0, done}, 32'd0);
      step();
      kill = 1'b0;
      check("kill_t11_busy", {31'd0, busy}, 32'd0);
      check("kill_t11_done", {31'd0, done}, 32'd0);
      check("kill_result_kept", result, 32'd0);
      step();
      run_op("after_kill", 3'b101, 32'd1000, 32'd10, 32'd100, 33);

      // kill with start in IDLE blocks the accept
      ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000; start = 1'b1; kill = 1'b1;
      step();
      start = 1'b0; kill = 1'b0;
      check("kill_start_busy", {31'd0, busy}, 32'd0);

      // 6. async reset mid-multiply
      do_start(3'b000, 32'd3, 32'd5);
      repeat (19) step();
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0; #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_result", result, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // non-M R-type start is not accepted
      ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'b000;
      operand_a = 32'd9; operand_b = 32'd9; start = 1'b1; #1;
      check("md_sel_off", {31'd0, md_sel}, 32'd0);
      step();
      start = 1'b0;
      check("no_accept_busy", {31'd0, busy}, 32'd0);
      step();
      check("no_accept_done", {31'd0, done}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
